// File: rtl/video_timing_out.sv
// VGA timing generator and output stage: pixel coordinates for the shader,
// sync/blank delayed by the shader latency, then registered onto the pins.
module video_timing_out #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int PIPE     = 0,
    parameter int COORD_W  = 10,
    parameter int COLOR_W  = 4
) (
    input  logic               clk_pix,
    input  logic               rst_pix,
    input  logic               en,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               line_start,
    output logic               frame_start,
    input  logic [COLOR_W-1:0] r_in,
    input  logic [COLOR_W-1:0] g_in,
    input  logic [COLOR_W-1:0] b_in,
    output logic [COLOR_W-1:0] vga_r,
    output logic [COLOR_W-1:0] vga_g,
    output logic [COLOR_W-1:0] vga_b,
    output logic               vga_hsync,
    output logic               vga_vsync
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(H_TOTAL - 1);
    localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(V_TOTAL - 1);
    localparam logic [COORD_W-1:0] H_ACT    = COORD_W'(H_ACTIVE);
    localparam logic [COORD_W-1:0] V_ACT    = COORD_W'(V_ACTIVE);
    localparam logic [COORD_W-1:0] HS_START = COORD_W'(H_ACTIVE + H_FP);
    localparam logic [COORD_W-1:0] HS_END   = COORD_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [COORD_W-1:0] VS_START = COORD_W'(V_ACTIVE + V_FP);
    localparam logic [COORD_W-1:0] VS_END   = COORD_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [COORD_W-1:0] C_ONE    = COORD_W'(1);

    logic [COORD_W-1:0] r_x;
    logic [COORD_W-1:0] r_y;
    logic               w_active;
    logic               w_hs;
    logic               w_vs;
    logic [2:0]         w_raw;
    logic [2:0]         w_dly;

    logic [COLOR_W-1:0] r_vga_r;
    logic [COLOR_W-1:0] r_vga_g;
    logic [COLOR_W-1:0] r_vga_b;
    logic               r_vga_hsync;
    logic               r_vga_vsync;

    // Both wraps resolve on the same edge, so (0, V_TOTAL) is never visible.
    always_ff @(posedge clk_pix or posedge rst_pix) begin
        if (rst_pix) begin
            r_x <= '0;
            r_y <= '0;
        end else if (en) begin
            if (r_x == H_LAST) begin
                r_x <= '0;
                r_y <= (r_y == V_LAST) ? '0 : r_y + C_ONE;
            end else begin
                r_x <= r_x + C_ONE;
            end
        end
    end

    assign w_active = (r_x < H_ACT) && (r_y < V_ACT);
    assign w_hs     = (r_x >= HS_START) && (r_x < HS_END);
    assign w_vs     = (r_y >= VS_START) && (r_y < VS_END);
    assign w_raw    = {w_active, w_hs, w_vs};

    // Delay stages hold raw (polarity-free) flags; reset means blank, no sync.
    generate
        if (PIPE == 0) begin : g_no_dly
            assign w_dly = w_raw;
        end else begin : g_dly
            logic [2:0] r_sr [PIPE];

            always_ff @(posedge clk_pix or posedge rst_pix) begin
                if (rst_pix) begin
                    for (int i = 0; i < PIPE; i++) begin
                        r_sr[i] <= 3'b000;
                    end
                end else if (en) begin
                    r_sr[0] <= w_raw;
                    for (int i = 1; i < PIPE; i++) begin
                        r_sr[i] <= r_sr[i-1];
                    end
                end
            end

            assign w_dly = r_sr[PIPE-1];
        end
    endgenerate

    always_ff @(posedge clk_pix or posedge rst_pix) begin
        if (rst_pix) begin
            r_vga_r     <= '0;
            r_vga_g     <= '0;
            r_vga_b     <= '0;
            r_vga_hsync <= ~HS_POL;
            r_vga_vsync <= ~VS_POL;
        end else if (en) begin
            r_vga_r     <= w_dly[2] ? r_in : '0;
            r_vga_g     <= w_dly[2] ? g_in : '0;
            r_vga_b     <= w_dly[2] ? b_in : '0;
            r_vga_hsync <= w_dly[1] ? HS_POL : ~HS_POL;
            r_vga_vsync <= w_dly[0] ? VS_POL : ~VS_POL;
        end
    end

    assign x           = r_x;
    assign y           = r_y;
    assign line_start  = (r_x == '0);
    assign frame_start = (r_x == '0) && (r_y == '0);
    assign vga_r       = r_vga_r;
    assign vga_g       = r_vga_g;
    assign vga_b       = r_vga_b;
    assign vga_hsync   = r_vga_hsync;
    assign vga_vsync   = r_vga_vsync;

endmodule

// File: tb/tb_video_timing_out.sv
// Bench for video_timing_out: default 640x480 timing, a PIPE=3 latency
// instance and a tiny positive-polarity instance checked against a vector table.
module tb_video_timing_out;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Instance A: default parameters, PIPE=0
    logic       en_a;
    logic [9:0] a_x, a_y;
    logic       a_ls, a_fs, a_hs, a_vs;
    logic [3:0] a_r, a_g, a_b;
    logic [3:0] a_rin, a_gin, a_bin;

    video_timing_out u_a (
        .clk_pix(clk), .rst_pix(rst), .en(en_a),
        .x(a_x), .y(a_y), .line_start(a_ls), .frame_start(a_fs),
        .r_in(a_rin), .g_in(a_gin), .b_in(a_bin),
        .vga_r(a_r), .vga_g(a_g), .vga_b(a_b),
        .vga_hsync(a_hs), .vga_vsync(a_vs)
    );

    // Instance B: default horizontal, short vertical, PIPE=3
    logic       en_b;
    logic [9:0] b_x, b_y;
    logic       b_ls, b_fs, b_hs, b_vs;
    logic [3:0] b_r, b_g, b_b;
    logic [3:0] b_rin;

    video_timing_out #(
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .PIPE(3)
    ) u_b (
        .clk_pix(clk), .rst_pix(rst), .en(en_b),
        .x(b_x), .y(b_y), .line_start(b_ls), .frame_start(b_fs),
        .r_in(b_rin), .g_in(4'h0), .b_in(4'h0),
        .vga_r(b_r), .vga_g(b_g), .vga_b(b_b),
        .vga_hsync(b_hs), .vga_vsync(b_vs)
    );

    // Instance C: tiny resolution, positive sync polarity
    logic       en_c;
    logic [9:0] c_x, c_y;
    logic       c_ls, c_fs, c_hs, c_vs;
    logic [3:0] c_r, c_g, c_b;

    video_timing_out #(
        .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b1)
    ) u_c (
        .clk_pix(clk), .rst_pix(rst), .en(en_c),
        .x(c_x), .y(c_y), .line_start(c_ls), .frame_start(c_fs),
        .r_in(4'hA), .g_in(4'h0), .b_in(4'h0),
        .vga_r(c_r), .vga_g(c_g), .vga_b(c_b),
        .vga_hsync(c_hs), .vga_vsync(c_vs)
    );

    typedef struct {
        int adv;
        int ex;
        int ey;
        int els;
        int efs;
        int ehs;
        int evs;
        int er;
    } vec_t;

    vec_t vecs[14];

    function automatic int pix_x(input int p);
        return (p % 5600) % 800;
    endfunction

    function automatic int pix_y(input int p);
        return (p % 5600) / 800;
    endfunction

    initial begin
        int errs;
        int fall1, rise1, fall2;
        int prev_hs;
        int m;
        int px, py, pr, phs, pvs;
        int k_fall, k_rise, m_fall;
        int exp_r;
        logic [3:0] xr;

        // edges-since-reset for instance C: H_TOTAL=12, V_TOTAL=7
        vecs[0]  = '{0,  0, 0, 1, 1, 0, 0, 0};
        vecs[1]  = '{1,  1, 0, 0, 0, 0, 0, 10};
        vecs[2]  = '{8,  9, 0, 0, 0, 0, 0, 0};
        vecs[3]  = '{1, 10, 0, 0, 0, 1, 0, 0};
        vecs[4]  = '{1, 11, 0, 0, 0, 1, 0, 0};
        vecs[5]  = '{1,  0, 1, 1, 0, 0, 0, 0};
        vecs[6]  = '{1,  1, 1, 0, 0, 0, 0, 10};
        vecs[7]  = '{47, 0, 5, 1, 0, 0, 0, 0};
        vecs[8]  = '{1,  1, 5, 0, 0, 0, 1, 0};
        vecs[9]  = '{11, 0, 6, 1, 0, 0, 1, 0};
        vecs[10] = '{1,  1, 6, 0, 0, 0, 0, 0};
        vecs[11] = '{10, 11, 6, 0, 0, 1, 0, 0};
        vecs[12] = '{1,  0, 0, 1, 1, 0, 0, 0};
        vecs[13] = '{1,  1, 0, 0, 0, 0, 0, 10};

        rst   = 1'b1;
        en_a  = 1'b1;
        en_b  = 1'b1;
        en_c  = 1'b1;
        a_rin = 4'h5;
        a_gin = 4'h3;
        a_bin = 4'hC;
        b_rin = 4'hF;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_a_r", a_r, 0);
        chk("rst_a_g", a_g, 0);
        chk("rst_a_b", a_b, 0);
        chk("rst_a_hs", a_hs, 1);
        chk("rst_a_vs", a_vs, 1);
        chk("rst_a_x", a_x, 0);
        chk("rst_a_y", a_y, 0);
        chk("rst_a_fs", a_fs, 1);
        chk("rst_a_ls", a_ls, 1);
        chk("rst_b_r", b_r, 0);
        chk("rst_b_hs", b_hs, 1);
        chk("rst_c_hs", c_hs, 0);
        chk("rst_c_vs", c_vs, 0);

        @(negedge clk);
        rst  = 1'b0;
        en_b = 1'b0;
        en_c = 1'b0;

        // default line timing on A
        errs = 0; fall1 = -1; rise1 = -1; fall2 = -1; prev_hs = 1;
        for (int t = 1; t <= 1610; t++) begin
            @(posedge clk);
            #1;
            if (t == 1) begin
                chk("a_first_x", a_x, 1);
                chk("a_first_ls", a_ls, 0);
                chk("a_first_r", a_r, 5);
                chk("a_first_g", a_g, 3);
                chk("a_first_b", a_b, 12);
            end
            if (t == 641) chk("a_r_past_active", a_r, 0);
            if (t == 800) begin
                chk("a_wrap_ls", a_ls, 1);
                chk("a_wrap_y", a_y, 1);
                chk("a_wrap_fs", a_fs, 0);
            end
            if (a_x != 10'(t % 800) || a_y != 10'(t / 800) || a_vs != 1'b1) errs++;
            if (prev_hs == 1 && a_hs == 1'b0) begin
                if (fall1 < 0) fall1 = t;
                else if (fall2 < 0) fall2 = t;
            end
            if (prev_hs == 0 && a_hs == 1'b1 && rise1 < 0) rise1 = t;
            prev_hs = int'(a_hs);
        end
        chk("a_track", errs, 0);
        chk("a_hs_fall", fall1, 657);
        chk("a_hs_width", rise1 - fall1, 96);
        chk("a_hs_period", fall2 - fall1, 800);

        // async reset mid-frame: A sits at (10,2) showing active colour
        chk("a_pre_rst_r", a_r, 5);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("async_x", a_x, 0);
        chk("async_y", a_y, 0);
        chk("async_r", a_r, 0);
        chk("async_fs", a_fs, 1);
        chk("async_hs", a_hs, 1);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // clock-enable toggling on A
        errs = 0; m = 0; k_fall = -1; k_rise = -1; m_fall = -1;
        px = 0; py = 0; pr = 0; phs = 1; pvs = 1;
        for (int k = 0; k < 1600; k++) begin
            en_a = (k % 2 == 0);
            @(posedge clk);
            #1;
            if (en_a) begin
                m++;
                if (a_x != 10'(m % 800) || a_y != 10'(m / 800)) errs++;
            end else begin
                if (int'(a_x) != px || int'(a_y) != py || int'(a_r) != pr ||
                    int'(a_hs) != phs || int'(a_vs) != pvs) errs++;
            end
            if (phs == 1 && a_hs == 1'b0 && k_fall < 0) begin
                k_fall = k;
                m_fall = m;
            end
            if (phs == 0 && a_hs == 1'b1 && k_rise < 0) k_rise = k;
            px = int'(a_x); py = int'(a_y); pr = int'(a_r);
            phs = int'(a_hs); pvs = int'(a_vs);
        end
        en_a = 1'b0;
        chk("en_hold_track", errs, 0);
        chk("en_hs_fall_enabled", m_fall, 657);
        chk("en_hs_width_clocks", k_rise - k_fall, 192);

        // small positive-polarity instance, table-driven
        en_c = 1'b1;
        foreach (vecs[i]) begin
            repeat (vecs[i].adv) begin
                @(posedge clk);
                #1;
            end
            chk($sformatf("c_x[%0d]", i), c_x, vecs[i].ex);
            chk($sformatf("c_y[%0d]", i), c_y, vecs[i].ey);
            chk($sformatf("c_ls[%0d]", i), c_ls, vecs[i].els);
            chk($sformatf("c_fs[%0d]", i), c_fs, vecs[i].efs);
            chk($sformatf("c_hs[%0d]", i), c_hs, vecs[i].ehs);
            chk($sformatf("c_vs[%0d]", i), c_vs, vecs[i].evs);
            chk($sformatf("c_r[%0d]", i), c_r, vecs[i].er);
        end
        en_c = 1'b0;

        // PIPE=3 latency: r_in is the column of the pixel three cycles back
        en_b = 1'b1;
        errs = 0;
        for (int n = 0; n < 5610; n++) begin
            xr = 4'(pix_x(n - 3));
            b_rin = (n >= 3) ? xr : 4'hF;
            @(posedge clk);
            #1;
            if (n + 1 >= 4 && pix_x(n - 3) < 640 && pix_y(n - 3) < 4)
                exp_r = pix_x(n - 3) % 16;
            else
                exp_r = 0;
            if (int'(b_r) != exp_r) errs++;
            if (int'(b_x) != pix_x(n + 1) || int'(b_y) != pix_y(n + 1)) errs++;
            case (n + 1)
                3:    chk("b_blank_refill", b_r, 0);
                9:    chk("b_r_col5", b_r, 5);
                643:  chk("b_r_col639", b_r, 15);
                644:  chk("b_r_col640", b_r, 0);
                659:  chk("b_hs_before", b_hs, 1);
                660:  chk("b_hs_fall", b_hs, 0);
                3209: chk("b_r_vblank", b_r, 0);
                5600: chk("b_frame_start", b_fs, 1);
                5609: chk("b_r_next_frame", b_r, 5);
                default: ;
            endcase
        end
        en_b = 1'b0;
        chk("b_track", errs, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
